// File: rtl/tap_sel_pkg.sv
// Shared types and helpers for the tap selector.
//   state_e : collection FSM states
//   SLOT_W  : width of one tap slot in the packed taps vector
//   tap_w() : number of din bits forming a candidate for a given SIZE
package tap_sel_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FIX     = 2'd2,
      DONE    = 2'd3
   } state_e;

   localparam int unsigned SLOT_W = 8;

   function automatic int unsigned tap_w(input int unsigned size);
      return $clog2(size);
   endfunction

endpackage

// File: rtl/tap_match.sv
// Combinational duplicate detector.
//   cand  : candidate tap value (zero-extended to SLOT_W)
//   slots : packed slot register, slot i at [i*SLOT_W +: SLOT_W]
//   idx   : number of slots currently holding accepted taps
//   hit   : cand equals one of slots 0..idx-1
module tap_match
   import tap_sel_pkg::*;
#(
   parameter int unsigned NUM_OF_TAPS = 15,
   parameter int unsigned IDX_W       = 4
) (
   input  logic [SLOT_W-1:0]             cand,
   input  logic [NUM_OF_TAPS*SLOT_W-1:0] slots,
   input  logic [IDX_W-1:0]              idx,
   output logic                          hit
);

   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 0; i < NUM_OF_TAPS; i++) begin
         if ((i < 32'(idx)) && (slots[i*SLOT_W +: SLOT_W] == cand)) begin
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tap_selector.sv
// Collects NUM_OF_TAPS feedback-tap positions for a SIZE-bit shift register
// from a random byte stream, guaranteeing tap SIZE-1 is in the final set.
//   clk, res  : clock, asynchronous active-high reset
//   ena       : global enable, low freezes everything
//   start     : clear slots and (re)start collection
//   din, take : random byte and its valid strobe
//   take_rdy  : candidates are consumed this cycle (COLLECT)
//   taps      : slot i at [i*8 +: 8], zero-extended tap value
//   busy      : COLLECT or FIX
//   done      : taps are final
//   rej_cnt   : saturating count of rejected candidates since start
module tap_selector
   import tap_sel_pkg::*;
#(
   parameter int unsigned NUM_OF_TAPS = 15,
   parameter int unsigned SIZE        = 32,
   parameter int unsigned UNIQUE      = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          res,
   input  logic                          ena,
   input  logic                          start,
   input  logic [7:0]                    din,
   input  logic                          take,
   output logic                          take_rdy,
   output logic [NUM_OF_TAPS*SLOT_W-1:0] taps,
   output logic                          busy,
   output logic                          done,
   output logic [CNT_W-1:0]              rej_cnt
);

   localparam int unsigned TAP_W    = tap_w(SIZE);
   localparam int unsigned IDX_W    = $clog2(NUM_OF_TAPS + 1);
   localparam logic [SLOT_W-1:0] MAX_TAP  = SLOT_W'(SIZE - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_OF_TAPS - 1);

   if ((UNIQUE != 0) && (NUM_OF_TAPS > SIZE - 1)) begin : g_cfg_chk
      $error("tap_selector: UNIQUE requires NUM_OF_TAPS <= SIZE-1");
   end

   state_e                      state_q, state_d;
   logic [NUM_OF_TAPS*SLOT_W-1:0] taps_q, taps_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic                        max_seen_q, max_seen_d;
   logic [CNT_W-1:0]            rej_cnt_q, rej_cnt_d;

   logic [SLOT_W-1:0] cand;
   logic              hit;
   logic              accept;
   logic              din_unused;

   assign cand       = SLOT_W'(din[TAP_W-1:0]);
   assign din_unused = ^din;

   tap_match #(
      .NUM_OF_TAPS (NUM_OF_TAPS),
      .IDX_W       (IDX_W)
   ) u_match (
      .cand  (cand),
      .slots (taps_q),
      .idx   (idx_q),
      .hit   (hit)
   );

   // Range check is redundant for power-of-two SIZE but kept for safety.
   assign accept = (cand != '0) && (cand <= MAX_TAP) && !((UNIQUE != 0) && hit);

   always_comb begin
      state_d    = state_q;
      taps_d     = taps_q;
      idx_d      = idx_q;
      max_seen_d = max_seen_q;
      rej_cnt_d  = rej_cnt_q;
      if (ena) begin
         if (start) begin
            // start beats a simultaneous take: the candidate is dropped uncounted
            taps_d     = '0;
            idx_d      = '0;
            max_seen_d = 1'b0;
            rej_cnt_d  = '0;
            state_d    = COLLECT;
         end else begin
            unique case (state_q)
               COLLECT: begin
                  if (take) begin
                     if (accept) begin
                        taps_d[32'(idx_q)*SLOT_W +: SLOT_W] = cand;
                        idx_d = idx_q + IDX_W'(1);
                        if (cand == MAX_TAP) max_seen_d = 1'b1;
                        if (idx_q == LAST_IDX) state_d = FIX;
                     end else if (rej_cnt_q != '1) begin
                        rej_cnt_d = rej_cnt_q + CNT_W'(1);
                     end
                  end
               end
               FIX: begin
                  // Highest power missing: sacrifice the first accepted tap for it.
                  if (!max_seen_q) taps_d[SLOT_W-1:0] = MAX_TAP;
                  state_d = DONE;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q    <= IDLE;
         taps_q     <= '0;
         idx_q      <= '0;
         max_seen_q <= 1'b0;
         rej_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         taps_q     <= taps_d;
         idx_q      <= idx_d;
         max_seen_q <= max_seen_d;
         rej_cnt_q  <= rej_cnt_d;
      end
   end

   assign take_rdy = (state_q == COLLECT);
   assign busy     = (state_q == COLLECT) || (state_q == FIX);
   assign done     = (state_q == DONE);
   assign taps     = taps_q;
   assign rej_cnt  = rej_cnt_q;

endmodule

// File: tb/tb_tap_selector.sv
// Bench for tap_selector: instance 0 with UNIQUE=1, instance 1 with UNIQUE=0,
// both driven by the same stimulus and compared against a list-based model.
module tb_tap_selector;

   localparam int unsigned NT   = 4;
   localparam int unsigned SZ   = 32;
   localparam int unsigned CW   = 16;

   logic clk, res, ena, start, take;
   logic [7:0] din;

   logic          tr [2];
   logic          bz [2];
   logic          dn [2];
   logic [31:0]   tp [2];
   logic [CW-1:0] rc [2];

   int n_cmp = 0;
   int n_mis = 0;

   // model: accepted values in order, and cycles elapsed since the set filled
   int ms   [2][NT];
   int mcnt [2];
   int mrej [2];
   int mage [2];
   bit mrun [2];

   tap_selector #(.NUM_OF_TAPS(NT), .SIZE(SZ), .UNIQUE(1), .CNT_W(CW)) u_dut0 (
      .clk(clk), .res(res), .ena(ena), .start(start), .din(din), .take(take),
      .take_rdy(tr[0]), .taps(tp[0]), .busy(bz[0]), .done(dn[0]), .rej_cnt(rc[0]));

   tap_selector #(.NUM_OF_TAPS(NT), .SIZE(SZ), .UNIQUE(0), .CNT_W(CW)) u_dut1 (
      .clk(clk), .res(res), .ena(ena), .start(start), .din(din), .take(take),
      .take_rdy(tr[1]), .taps(tp[1]), .busy(bz[1]), .done(dn[1]), .rej_cnt(rc[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         mcnt[u] = 0; mrej[u] = 0; mage[u] = -1; mrun[u] = 1'b0;
      end
   endtask

   task automatic model_step();
      int cand;
      bit dup;
      for (int u = 0; u < 2; u++) begin
         if (ena) begin
            if (start) begin
               mcnt[u] = 0; mrej[u] = 0; mage[u] = -1; mrun[u] = 1'b1;
            end else if (mage[u] == 0) begin
               mage[u] = 1;
            end else if (mrun[u] && mcnt[u] < NT && take) begin
               cand = int'(din) % SZ;
               dup = 1'b0;
               if (u == 0)
                  for (int j = 0; j < mcnt[u]; j++) if (ms[u][j] == cand) dup = 1'b1;
               if (cand != 0 && cand <= SZ - 1 && !dup) begin
                  ms[u][mcnt[u]] = cand;
                  mcnt[u]++;
                  if (mcnt[u] == NT) mage[u] = 0;
               end else if (mrej[u] < (1 << CW) - 1) begin
                  mrej[u]++;
               end
            end
         end
      end
   endtask

   function automatic logic [31:0] exp_taps(input int u);
      logic [31:0] v;
      bit has_max;
      v = '0;
      has_max = 1'b0;
      for (int i = 0; i < mcnt[u]; i++) begin
         v[i*8 +: 8] = 8'(ms[u][i]);
         if (ms[u][i] == SZ - 1) has_max = 1'b1;
      end
      if (mage[u] >= 1 && !has_max) v[7:0] = 8'(SZ - 1);
      return v;
   endfunction

   task automatic compare_all();
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d take_rdy", u), 64'(tr[u]), 64'(mrun[u] && mcnt[u] < NT));
         chk($sformatf("u%0d busy", u), 64'(bz[u]), 64'((mrun[u] && mcnt[u] < NT) || mage[u] == 0));
         chk($sformatf("u%0d done", u), 64'(dn[u]), 64'(mage[u] >= 1));
         chk($sformatf("u%0d rej_cnt", u), 64'(rc[u]), 64'(mrej[u]));
         chk($sformatf("u%0d taps", u), 64'(tp[u]), 64'(exp_taps(u)));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic drive(input bit e, input bit s, input bit t, input logic [7:0] d);
      ena = e; start = s; take = t; din = d;
      tick();
   endtask

   // Called at posedge+1: reset lands mid-cycle and is checked before any edge.
   task automatic async_reset();
      #3 res = 1'b1;
      #1;
      model_reset();
      compare_all();
      chk("async taps zero", 64'(tp[0]), 64'd0);
      #2 res = 1'b0;
   endtask

   initial begin
      int seq1 [4] = '{3, 5, 9, 12};
      int seq2 [6] = '{0, 31, 5, 5, 7, 2};
      res = 1'b1; ena = 1'b0; start = 1'b0; take = 1'b0; din = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      res = 1'b0;
      drive(1, 0, 1, 8'd7);   // takes ignored in IDLE

      // 1: no 31 seen, FIX forces slot 0
      drive(1, 1, 0, 8'd0);
      foreach (seq1[i]) drive(1, 0, 1, 8'(seq1[i]));
      chk("t1 fix busy", 64'(bz[0]), 64'd1);
      chk("t1 fix not done", 64'(dn[0]), 64'd0);
      drive(1, 0, 0, 8'd0);
      chk("t1 done latency", 64'(dn[0]), 64'd1);
      chk("t1 taps", 64'(tp[0]), 64'h0C09051F);
      drive(1, 0, 1, 8'd17);  // DONE holds taps

      // 2: zero and duplicate rejected, 31 present
      drive(1, 1, 0, 8'd0);
      foreach (seq2[i]) drive(1, 0, 1, 8'(seq2[i]));
      repeat (2) drive(1, 0, 0, 8'd0);
      chk("t2 taps", 64'(tp[0]), 64'h0207051F);
      chk("t2 rej_cnt", 64'(rc[0]), 64'd2);

      // 3: duplicates allowed on instance 1
      drive(1, 1, 0, 8'd0);
      repeat (4) drive(1, 0, 1, 8'd4);
      repeat (2) drive(1, 0, 0, 8'd0);
      chk("t3 taps u1", 64'(tp[1]), 64'h0404041F);
      chk("t3 rej u1", 64'(rc[1]), 64'd0);

      // 4: ena low freezes mid-collection
      drive(1, 1, 0, 8'd0);
      drive(1, 0, 1, 8'd1);
      drive(1, 0, 1, 8'd2);
      repeat (5) drive(0, 1, 1, 8'($urandom));
      drive(1, 0, 1, 8'd3);
      drive(1, 0, 1, 8'd4);
      repeat (2) drive(1, 0, 0, 8'd0);

      // 5: async reset after two accepts
      drive(1, 1, 0, 8'd0);
      drive(1, 0, 1, 8'd10);
      drive(1, 0, 1, 8'd11);
      async_reset();
      repeat (3) drive(1, 0, 1, 8'd5);

      // 6: start with take during DONE
      drive(1, 1, 0, 8'd0);
      for (int i = 1; i <= 4; i++) drive(1, 0, 1, 8'(i));
      repeat (2) drive(1, 0, 0, 8'd0);
      drive(1, 1, 1, 8'd6);
      chk("t6 taps cleared", 64'(tp[0]), 64'd0);
      chk("t6 collecting", 64'(tr[0]), 64'd1);
      drive(1, 0, 1, 8'd6);

      // random
      for (int n = 0; n < 4000; n++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 3) != 0, 8'($urandom));
         if ($urandom_range(0, 499) == 0) async_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
